// File: rtl/imm_pkg.sv
// Shared field positions, widths and helpers for the immediate generator.
package imm_pkg;

  localparam int unsigned INSTR_W  = 11;
  localparam int unsigned IMM_OP_W = 3;

  // imm_op bit indices
  localparam int unsigned IMM_SEL  = 0;
  localparam int unsigned IMM_SH_A = 1;
  localparam int unsigned IMM_SH_B = 2;

  // instr field positions
  localparam int unsigned IMM7_HI_MSB = 10;
  localparam int unsigned IMM7_HI_LSB = 6;
  localparam int unsigned IMM7_LO_MSB = 1;
  localparam int unsigned IMM7_LO_LSB = 0;
  localparam int unsigned IMM9_MSB    = 10;
  localparam int unsigned IMM9_LSB    = 2;

  localparam int unsigned PFX_PAYLOAD_W = 9;
  localparam int unsigned IMM7_W        = 7;
  localparam int unsigned IMM9_W        = 9;

  // Kind of beat accepted on the input handshake this cycle.
  typedef enum logic [1:0] {
    BeatNone,
    BeatPrefix,
    BeatConsume
  } beat_kind_e;

  function automatic logic [IMM7_W-1:0] imm7_field(input logic [INSTR_W-1:0] instr);
    return {instr[IMM7_HI_MSB:IMM7_HI_LSB], instr[IMM7_LO_MSB:IMM7_LO_LSB]};
  endfunction

  function automatic logic [IMM9_W-1:0] imm9_field(input logic [INSTR_W-1:0] instr);
    return instr[IMM9_MSB:IMM9_LSB];
  endfunction

endpackage

// File: rtl/imm_base_format.sv
// Unprefixed immediate: field select, sign extension and the two optional shifts.
module imm_base_format
  import imm_pkg::*;
#(
  parameter int unsigned XLEN    = 16,
  parameter int unsigned SHIFT_A = 1,
  parameter int unsigned SHIFT_B = 7
) (
  input  logic [INSTR_W-1:0]  i_instr,
  input  logic [IMM_OP_W-1:0] i_imm_op,
  output logic [XLEN-1:0]     o_imm
);

  logic [IMM7_W-1:0] w_raw7;
  logic [IMM9_W-1:0] w_raw9;
  logic [XLEN-1:0]   w_sext;

  assign w_raw7 = imm7_field(i_instr);
  assign w_raw9 = imm9_field(i_instr);

  // Pick and sign-extend the raw field, then shift by A before B; overflow bits fall off.
  always_comb begin
    w_sext = {{(XLEN - IMM7_W){w_raw7[IMM7_W-1]}}, w_raw7};
    if (i_imm_op[IMM_SEL]) begin
      w_sext = {{(XLEN - IMM9_W){w_raw9[IMM9_W-1]}}, w_raw9};
    end
    o_imm = w_sext;
    if (i_imm_op[IMM_SH_A]) begin
      o_imm = o_imm << SHIFT_A;
    end
    if (i_imm_op[IMM_SH_B]) begin
      o_imm = o_imm << SHIFT_B;
    end
  end

endmodule

// File: rtl/imm_prefix_gen.sv
// Registered immediate generator with prefix chaining behind a valid/ready handshake.
module imm_prefix_gen
  import imm_pkg::*;
#(
  parameter int unsigned XLEN    = 16,
  parameter int unsigned SHIFT_A = 1,
  parameter int unsigned SHIFT_B = 7,
  parameter int unsigned MAX_PFX = (XLEN + 1) / PFX_PAYLOAD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instr,
  input  logic [IMM_OP_W-1:0] imm_op,
  input  logic                reg_zero,
  input  logic                is_prefix,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     imm,
  output logic                prefixed,
  output logic                pfx_ovf
);

  localparam int unsigned PFX_W  = PFX_PAYLOAD_W * MAX_PFX;
  localparam int unsigned CNT_W  = $clog2(MAX_PFX + 1);
  localparam int unsigned SEXT_W = XLEN - IMM7_W;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_PFX);

  logic [PFX_W-1:0] r_pfx;
  logic [CNT_W-1:0] r_pfx_cnt;
  logic             r_ovf_pend;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_imm;
  logic             r_prefixed;
  logic             r_pfx_ovf;

  beat_kind_e        w_beat;
  logic [PFX_W-1:0]  w_pfx_next;
  logic              w_pfx_armed;
  logic              w_use_pfx;
  logic              w_pfx_sign;
  logic [SEXT_W-1:0] w_fill_mask;
  logic [SEXT_W-1:0] w_pfx_sext;
  logic [XLEN-1:0]   w_pfx_imm;
  logic [XLEN-1:0]   w_base_imm;
  logic [XLEN-1:0]   w_result;

  imm_base_format #(
    .XLEN    (XLEN),
    .SHIFT_A (SHIFT_A),
    .SHIFT_B (SHIFT_B)
  ) u_base (
    .i_instr  (instr),
    .i_imm_op (imm_op),
    .o_imm    (w_base_imm)
  );

  assign in_ready    = !r_out_valid || out_ready;
  assign w_pfx_armed = (r_pfx_cnt != '0);
  assign w_use_pfx   = w_pfx_armed && !reg_zero;
  assign w_pfx_next  = (r_pfx << PFX_PAYLOAD_W) | PFX_W'(imm9_field(instr));

  // Classify the beat taken on the input handshake.
  always_comb begin
    w_beat = BeatNone;
    if (in_valid && in_ready) begin
      w_beat = is_prefix ? BeatPrefix : BeatConsume;
    end
  end

  // Sign-extend the retained payload from 9*pfx_cnt bits. Bits of r_pfx above that width
  // are always zero, so OR-ing in the sign fill is enough.
  always_comb begin
    w_pfx_sign  = 1'b0;
    w_fill_mask = '0;
    for (int k = 1; k <= int'(MAX_PFX); k++) begin
      if (int'(r_pfx_cnt) == k) begin
        w_pfx_sign = r_pfx[k*PFX_PAYLOAD_W-1];
      end
    end
    for (int i = 0; i < int'(SEXT_W); i++) begin
      w_fill_mask[i] = (i >= int'(r_pfx_cnt) * int'(PFX_PAYLOAD_W));
    end
    w_pfx_sext = SEXT_W'(r_pfx) | (w_pfx_sign ? w_fill_mask : '0);
    w_pfx_imm  = {w_pfx_sext, imm7_field(instr)};
  end

  // Result mux: zero forcing wins, then prefix chaining, else the base format.
  always_comb begin
    w_result = w_base_imm;
    if (reg_zero) begin
      w_result = '0;
    end else if (w_pfx_armed) begin
      w_result = w_pfx_imm;
    end
  end

  // Prefix accumulator: shift in payloads, saturate the count, flag lost high bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pfx      <= '0;
      r_pfx_cnt  <= '0;
      r_ovf_pend <= 1'b0;
    end else if (flush) begin
      r_pfx      <= '0;
      r_pfx_cnt  <= '0;
      r_ovf_pend <= 1'b0;
    end else begin
      unique case (w_beat)
        BeatPrefix: begin
          r_pfx <= w_pfx_next;
          if (r_pfx_cnt == CntMax) begin
            r_ovf_pend <= 1'b1;
          end else begin
            r_pfx_cnt <= r_pfx_cnt + CNT_W'(1);
          end
        end
        BeatConsume: begin
          r_pfx      <= '0;
          r_pfx_cnt  <= '0;
          r_ovf_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Output register: load on a consumer beat, hold while stalled, drop after handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_prefixed  <= 1'b0;
      r_pfx_ovf   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_prefixed  <= 1'b0;
      r_pfx_ovf   <= 1'b0;
    end else if (w_beat == BeatConsume) begin
      r_out_valid <= 1'b1;
      r_imm       <= w_result;
      r_prefixed  <= w_use_pfx;
      r_pfx_ovf   <= w_use_pfx && r_ovf_pend;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign imm       = r_imm;
  assign prefixed  = r_prefixed;
  assign pfx_ovf   = r_pfx_ovf;

endmodule

// File: tb/tb_imm_prefix_gen.sv
// Bench for imm_prefix_gen: XLEN=16 and XLEN=32 instances share one stimulus stream and
// are checked every cycle against an arithmetic model, plus hand-computed literals.
module tb_imm_prefix_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        reg_zero = 1'b0;
  logic        is_prefix = 1'b0;
  logic [10:0] instr = '0;
  logic [2:0]  imm_op = '0;

  logic        in_ready16, out_valid16, prefixed16, pfx_ovf16;
  logic [15:0] imm16;
  logic        in_ready32, out_valid32, prefixed32, pfx_ovf32;
  logic [31:0] imm32;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  imm_prefix_gen #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready16),
    .instr(instr), .imm_op(imm_op), .reg_zero(reg_zero), .is_prefix(is_prefix),
    .out_valid(out_valid16), .out_ready(out_ready), .imm(imm16), .prefixed(prefixed16),
    .pfx_ovf(pfx_ovf16)
  );

  imm_prefix_gen #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_op(imm_op), .reg_zero(reg_zero), .is_prefix(is_prefix),
    .out_valid(out_valid32), .out_ready(out_ready), .imm(imm32), .prefixed(prefixed32),
    .pfx_ovf(pfx_ovf32)
  );

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit          m_valid = 1'b0;
  longint      m_imm16 = 0;
  longint      m_imm32 = 0;
  bit          m_pref = 1'b0;
  bit          m_ovf16 = 1'b0;
  bit          m_ovf32 = 1'b0;
  int unsigned pq[$];
  logic        m_acc;

  assign m_acc = in_valid && (!m_valid || out_ready);

  // Value a consumer beat must produce, from the history of prefix payloads.
  function automatic longint calc_imm(input int xlen, input int maxp);
    longint v;
    longint lim;
    int     n;
    int     k;
    int     w;
    n = pq.size();
    v = 0;
    if (reg_zero) begin
      v = 0;
    end else if (n > 0) begin
      k = (n > maxp) ? maxp : n;
      for (int j = n - k; j < n; j++) v = v * 512 + longint'(pq[j]);
      lim = longint'(1) << (9 * k);
      if (v >= lim / 2) v = v - lim;
      v = v * 128 + longint'({instr[10:6], instr[1:0]});
    end else begin
      if (imm_op[0]) begin
        v = longint'(instr[10:2]);
        w = 9;
      end else begin
        v = longint'({instr[10:6], instr[1:0]});
        w = 7;
      end
      lim = longint'(1) << w;
      if (v >= lim / 2) v = v - lim;
      if (imm_op[1]) v = v * 2;
      if (imm_op[2]) v = v * 128;
    end
    return v & ((longint'(1) << xlen) - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      pq.delete();
    end else if (flush) begin
      m_valid <= 1'b0;
      pq.delete();
    end else if (m_acc && !is_prefix) begin
      m_valid <= 1'b1;
      m_imm16 <= calc_imm(16, 1);
      m_imm32 <= calc_imm(32, 3);
      m_pref  <= !reg_zero && (pq.size() > 0);
      m_ovf16 <= !reg_zero && (pq.size() > 1);
      m_ovf32 <= !reg_zero && (pq.size() > 3);
      pq.delete();
    end else begin
      if (m_acc) pq.push_back(int'(instr[10:2]));
      if (out_ready) m_valid <= 1'b0;
    end
  end

  // Compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready16", longint'(in_ready16), longint'(!m_valid || out_ready));
      chk("in_ready32", longint'(in_ready32), longint'(!m_valid || out_ready));
      chk("out_valid16", longint'(out_valid16), longint'(m_valid));
      chk("out_valid32", longint'(out_valid32), longint'(m_valid));
      if (m_valid) begin
        chk("imm16", longint'(imm16), m_imm16);
        chk("imm32", longint'(imm32), m_imm32);
        chk("prefixed16", longint'(prefixed16), longint'(m_pref));
        chk("prefixed32", longint'(prefixed32), longint'(m_pref));
        chk("pfx_ovf16", longint'(pfx_ovf16), longint'(m_ovf16));
        chk("pfx_ovf32", longint'(pfx_ovf32), longint'(m_ovf32));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Present one beat and hold it until accepted; a stalled consumer is released after a cycle.
  task automatic send(input bit pfx, input logic [10:0] ins, input logic [2:0] op,
                      input bit rz);
    bit acc;
    acc = 1'b0;
    is_prefix = pfx;
    instr = ins;
    imm_op = op;
    reg_zero = rz;
    in_valid = 1'b1;
    for (int c = 0; c < 16 && !acc; c++) begin
      #1;
      acc = in_ready16;
      @(posedge clk);
      #1;
      if (!acc) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    chk("send_accepted", longint'(acc), 1);
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", longint'(out_valid16), 0);
    chk("rst_imm", longint'(imm16), 0);
    chk("rst_prefixed", longint'(prefixed16), 0);
    chk("rst_pfx_ovf", longint'(pfx_ovf16), 0);
    chk("rst_in_ready", longint'(in_ready16), 1);
    chk("rst_out_valid32", longint'(out_valid32), 0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          pfx;
    logic [10:0] ins;
    logic [2:0]  op;
    bit          rz;
    bit          ordy;
  } beat_t;

  beat_t tbl[12] = '{
    '{1'b0, 11'h403, 3'b000, 1'b0, 1'b1},
    '{1'b1, 11'h6AC, 3'b000, 1'b0, 1'b1},
    '{1'b0, 11'h541, 3'b111, 1'b0, 1'b0},
    '{1'b1, 11'h004, 3'b000, 1'b0, 1'b1},
    '{1'b1, 11'h008, 3'b000, 1'b0, 1'b1},
    '{0, 11'h7C1, 3'b110, 1'b0, 1'b1},
    '{1'b0, 11'h2AA, 3'b111, 1'b0, 1'b0},
    '{1'b1, 11'h7FC, 3'b000, 1'b0, 1'b1},
    '{1'b0, 11'h003, 3'b000, 1'b1, 1'b1},
    '{1'b0, 11'h1FF, 3'b001, 1'b0, 1'b1},
    '{1'b0, 11'h3FF, 3'b010, 1'b0, 1'b0},
    '{1'b0, 11'h7FF, 3'b101, 1'b1, 1'b1}
  };

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("reset_out_valid", longint'(out_valid16), 0);
    chk("reset_imm", longint'(imm16), 0);
    chk("reset_prefixed", longint'(prefixed16), 0);
    chk("reset_pfx_ovf", longint'(pfx_ovf16), 0);
    chk("reset_in_ready", longint'(in_ready16), 1);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Base formats and shifts
    send(0, 11'h403, 3'b000, 0);
    chk("t1_valid", longint'(out_valid16), 1);
    chk("t1_imm", longint'(imm16), 16'hFFC3);
    chk("t1_prefixed", longint'(prefixed16), 0);
    send(0, 11'h004, 3'b101, 0);
    chk("t2_imm_shb", longint'(imm16), 16'h0080);
    send(0, 11'h004, 3'b011, 0);
    chk("t2_imm_sha", longint'(imm16), 16'h0002);

    // Single prefix, back to back with its consumer
    send(1, 11'h6AC, 3'b000, 0);
    chk("t3_pfx_no_out", longint'(out_valid16), 0);
    send(0, 11'h541, 3'b000, 0);
    chk("t3_imm", longint'(imm16), 16'hD5D5);
    chk("t3_prefixed", longint'(prefixed16), 1);
    chk("t3_ovf", longint'(pfx_ovf16), 0);
    send(0, 11'h541, 3'b000, 0);
    chk("t3_after_imm", longint'(imm16), 16'hFFD5);
    chk("t3_after_pref", longint'(prefixed16), 0);

    // Two prefixes: overflow at 16 bits, chained at 32 bits
    send(1, 11'h004, 3'b000, 0);
    send(1, 11'h6AC, 3'b000, 0);
    send(0, 11'h541, 3'b000, 0);
    chk("t4_imm16", longint'(imm16), 16'hD5D5);
    chk("t4_ovf16", longint'(pfx_ovf16), 1);
    chk("t4_imm32", longint'(imm32), 32'h0001D5D5);
    chk("t4_ovf32", longint'(pfx_ovf32), 0);
    chk("t4_pref32", longint'(prefixed32), 1);

    // Three prefixes fill the 32-bit accumulator exactly, negative result
    send(1, 11'h7FC, 3'b000, 0);
    send(1, 11'h004, 3'b000, 0);
    send(1, 11'h008, 3'b000, 0);
    send(0, 11'h003, 3'b000, 0);
    chk("t5_imm32", longint'(imm32), 32'hFE010103);
    chk("t5_ovf32", longint'(pfx_ovf32), 0);
    chk("t5_imm16", longint'(imm16), 16'h0103);
    chk("t5_ovf16", longint'(pfx_ovf16), 1);

    // Four prefixes overflow the 32-bit accumulator
    repeat (4) send(1, 11'h004, 3'b000, 0);
    send(0, 11'h000, 3'b000, 0);
    chk("t6_imm32", longint'(imm32), 32'h02010080);
    chk("t6_ovf32", longint'(pfx_ovf32), 1);

    // Zero forcing still consumes an armed prefix
    send(1, 11'h6AC, 3'b000, 0);
    send(0, 11'h541, 3'b000, 1);
    chk("t7_zero_imm", longint'(imm16), 0);
    chk("t7_zero_pref", longint'(prefixed16), 0);
    send(0, 11'h541, 3'b000, 0);
    chk("t7_after_imm", longint'(imm16), 16'hFFD5);
    chk("t7_after_pref", longint'(prefixed16), 0);

    // Back-pressure: hold a beat for three cycles, then drain
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(0, 11'h0C1, 3'b000, 0);
    is_prefix = 1'b0;
    instr = 11'h2A5;
    imm_op = 3'b001;
    reg_zero = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("stall_in_ready", longint'(in_ready16), 0);
      chk("stall_imm", longint'(imm16), 16'h000D);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("drain_imm", longint'(imm16), 16'h00A9);
    chk("drain_valid", longint'(out_valid16), 1);
    send(0, 11'h403, 3'b000, 0);
    send(0, 11'h004, 3'b101, 0);
    @(posedge clk);
    #1;

    // Flush drops the armed prefix and a beat presented alongside it
    send(1, 11'h6AC, 3'b000, 0);
    flush = 1'b1;
    is_prefix = 1'b0;
    instr = 11'h541;
    imm_op = 3'b000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", longint'(out_valid16), 0);
    send(0, 11'h541, 3'b000, 0);
    chk("flush_imm", longint'(imm16), 16'hFFD5);
    chk("flush_pref", longint'(prefixed16), 0);

    // Directed mix with intermittent back-pressure
    foreach (tbl[i]) begin
      out_ready = tbl[i].ordy;
      send(tbl[i].pfx, tbl[i].ins, tbl[i].op, tbl[i].rz);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset while an output is held, then while a prefix is armed
    send(0, 11'h403, 3'b000, 0);
    out_ready = 1'b0;
    pulse_rst();
    out_ready = 1'b1;
    send(1, 11'h6AC, 3'b000, 0);
    pulse_rst();
    send(0, 11'h541, 3'b000, 0);
    chk("rst_pfx_cleared_imm", longint'(imm16), 16'hFFD5);
    chk("rst_pfx_cleared_pref", longint'(prefixed16), 0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
